// File: rtl/lpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_pkg
//  Description : Shared constants for the LPC host bridge: FSM state codes,
//                START / CYCTYPE / SYNC / TAR nibbles, the latched request
//                record and a CYCTYPE encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package lpc_pkg;

    // FSM state codes (also exported on ctrl_host_state_o)
    localparam logic [4:0] ST_IDLE     = 5'd0;
    localparam logic [4:0] ST_START    = 5'd1;
    localparam logic [4:0] ST_CYCTYPE  = 5'd2;
    localparam logic [4:0] ST_ADDR     = 5'd3;
    localparam logic [4:0] ST_WDATA_LO = 5'd4;
    localparam logic [4:0] ST_WDATA_HI = 5'd5;
    localparam logic [4:0] ST_HTAR1    = 5'd6;
    localparam logic [4:0] ST_HTAR2    = 5'd7;
    localparam logic [4:0] ST_SYNC     = 5'd8;
    localparam logic [4:0] ST_RDATA_LO = 5'd9;
    localparam logic [4:0] ST_RDATA_HI = 5'd10;
    localparam logic [4:0] ST_PTAR1    = 5'd11;
    localparam logic [4:0] ST_PTAR2    = 5'd12;

    // Nibbles driven by the host
    localparam logic [3:0] NIB_START   = 4'b0000;
    localparam logic [3:0] NIB_TAR     = 4'b1111;
    localparam logic [3:0] CYC_IO_RD   = 4'b0000;
    localparam logic [3:0] CYC_IO_WR   = 4'b0010;
    localparam logic [3:0] CYC_MEM_RD  = 4'b0100;
    localparam logic [3:0] CYC_MEM_WR  = 4'b0110;

    // SYNC codes returned by the peripheral
    localparam logic [3:0] SYNC_READY  = 4'b0000;
    localparam logic [3:0] SYNC_SWAIT  = 4'b0101;
    localparam logic [3:0] SYNC_LWAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERR    = 4'b1010;

    // Request captured from the controller side when a cycle is accepted
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic        mem;
    } lpc_req_t;

    function automatic logic [3:0] cyctype_nibble(input logic mem, input logic wr);
        logic [3:0] nib;
        case ({mem, wr})
            2'b00:   nib = CYC_IO_RD;
            2'b01:   nib = CYC_IO_WR;
            2'b10:   nib = CYC_MEM_RD;
            default: nib = CYC_MEM_WR;
        endcase
        return nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_host_bridge
//  Description : LPC host controller. Turns a level-sensitive parallel
//                request (address, data, rd/wr strobe, memory/IO select)
//                into START/CYCTYPE/ADDR/DATA/TAR/SYNC nibble sequences on
//                the tri-state LAD bus and returns read data + ready.
//  Ports       : clk_i, ctrl_nrst_i (async, active-low)
//                ctrl_addr_i[15:0], ctrl_data_i[7:0], ctrl_lframe_i (req, low)
//                ctrl_rd_status_i, ctrl_wr_status_i, ctrl_memory_cycle_i
//                ctrl_data_o[7:0], ctrl_ready_o, ctrl_host_state_o[4:0]
//                LPC_LAD[3:0] (inout), LPC_LCLK, LPC_LRESET, LPC_LFRAME
//  Revision    : 1.0  initial release
// ============================================================================
module lpc_host_bridge
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 8
) (
    input  logic        clk_i,
    input  logic        ctrl_nrst_i,
    input  logic [15:0] ctrl_addr_i,
    input  logic [7:0]  ctrl_data_i,
    input  logic        ctrl_lframe_i,
    input  logic        ctrl_rd_status_i,
    input  logic        ctrl_wr_status_i,
    input  logic        ctrl_memory_cycle_i,
    output logic [7:0]  ctrl_data_o,
    output logic        ctrl_ready_o,
    output logic [4:0]  ctrl_host_state_o,
    inout  wire logic [3:0] LPC_LAD,
    output logic        LPC_LCLK,
    output logic        LPC_LRESET,
    output logic        LPC_LFRAME
);

    localparam int TW = $clog2(SYNC_TIMEOUT + 1) + 1;

    logic [4:0]    state_q,   state_d;
    lpc_req_t      req_q,     req_d;
    logic [2:0]    nib_cnt_q, nib_cnt_d;
    logic [TW-1:0] to_cnt_q,  to_cnt_d;
    logic [3:0]    rlo_q,     rlo_d;
    logic [7:0]    data_q,    data_d;

    logic [31:0]   w_addr_ext;
    logic [2:0]    w_nib_last;
    logic [2:0]    w_nib_idx;
    logic [3:0]    w_addr_nib;
    logic          w_lad_oe;
    logic [3:0]    w_lad_out;

    // Memory cycles carry a 32-bit address whose upper half is zero; I/O
    // cycles send only the low 16 bits. Nibbles go out MSN first.
    assign w_addr_ext = {16'h0000, req_q.addr};
    assign w_nib_last = req_q.mem ? 3'd7 : 3'd3;
    assign w_nib_idx  = w_nib_last - nib_cnt_q;
    assign w_addr_nib = w_addr_ext[{w_nib_idx, 2'b00} +: 4];

    // Host owns LAD only from START through HTAR1.
    always_comb begin
        w_lad_oe  = 1'b0;
        w_lad_out = 4'h0;
        case (state_q)
            ST_START: begin
                w_lad_oe  = 1'b1;
                w_lad_out = NIB_START;
            end
            ST_CYCTYPE: begin
                w_lad_oe  = 1'b1;
                w_lad_out = cyctype_nibble(req_q.mem, req_q.wr);
            end
            ST_ADDR: begin
                w_lad_oe  = 1'b1;
                w_lad_out = w_addr_nib;
            end
            ST_WDATA_LO: begin
                w_lad_oe  = 1'b1;
                w_lad_out = req_q.data[3:0];
            end
            ST_WDATA_HI: begin
                w_lad_oe  = 1'b1;
                w_lad_out = req_q.data[7:4];
            end
            ST_HTAR1: begin
                w_lad_oe  = 1'b1;
                w_lad_out = NIB_TAR;
            end
            default: begin
                w_lad_oe  = 1'b0;
                w_lad_out = 4'h0;
            end
        endcase
    end

    assign LPC_LAD           = w_lad_oe ? w_lad_out : 4'bzzzz;
    assign LPC_LCLK          = clk_i;
    assign LPC_LRESET        = ctrl_nrst_i;
    assign LPC_LFRAME        = (state_q != ST_START);
    assign ctrl_ready_o      = (state_q == ST_IDLE);
    assign ctrl_host_state_o = state_q;
    assign ctrl_data_o       = data_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        nib_cnt_d = nib_cnt_q;
        to_cnt_d  = to_cnt_q;
        rlo_d     = rlo_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                // Level-sensitive request; write wins when both strobes are set.
                if (!ctrl_lframe_i && (ctrl_rd_status_i || ctrl_wr_status_i)) begin
                    req_d.addr = ctrl_addr_i;
                    req_d.data = ctrl_data_i;
                    req_d.wr   = ctrl_wr_status_i;
                    req_d.mem  = ctrl_memory_cycle_i;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                nib_cnt_d = 3'd0;
                state_d   = ST_CYCTYPE;
            end
            ST_CYCTYPE: state_d = ST_ADDR;
            ST_ADDR: begin
                if (nib_cnt_q == w_nib_last) begin
                    nib_cnt_d = 3'd0;
                    state_d   = req_q.wr ? ST_WDATA_LO : ST_HTAR1;
                end else begin
                    nib_cnt_d = nib_cnt_q + 3'd1;
                end
            end
            ST_WDATA_LO: state_d = ST_WDATA_HI;
            ST_WDATA_HI: state_d = ST_HTAR1;
            ST_HTAR1:    state_d = ST_HTAR2;
            ST_HTAR2: begin
                to_cnt_d = '0;
                state_d  = ST_SYNC;
            end
            ST_SYNC: begin
                case (LPC_LAD)
                    SYNC_READY, SYNC_ERR: begin
                        to_cnt_d = '0;
                        state_d  = req_q.wr ? ST_PTAR1 : ST_RDATA_LO;
                    end
                    SYNC_SWAIT, SYNC_LWAIT: begin
                        // A valid wait code breaks any run of garbage.
                        to_cnt_d = '0;
                    end
                    default: begin
                        if (to_cnt_q == TW'(SYNC_TIMEOUT - 1)) begin
                            to_cnt_d = '0;
                            state_d  = ST_IDLE;
                            if (!req_q.wr) begin
                                data_d = 8'hFF;
                            end
                        end else begin
                            to_cnt_d = to_cnt_q + TW'(1);
                        end
                    end
                endcase
            end
            ST_RDATA_LO: begin
                rlo_d   = LPC_LAD;
                state_d = ST_RDATA_HI;
            end
            ST_RDATA_HI: begin
                data_d  = {LPC_LAD, rlo_q};
                state_d = ST_PTAR1;
            end
            ST_PTAR1: state_d = ST_PTAR2;
            ST_PTAR2: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge ctrl_nrst_i) begin
        if (!ctrl_nrst_i) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            nib_cnt_q <= 3'd0;
            to_cnt_q  <= '0;
            rlo_q     <= 4'h0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            nib_cnt_q <= nib_cnt_d;
            to_cnt_q  <= to_cnt_d;
            rlo_q     <= rlo_d;
            data_q    <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpc_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpc_host_bridge
//  Description : Self-checking bench for lpc_host_bridge. A transaction-level
//                model expands each LPC cycle into the expected per-clock bus
//                picture; the bench plays the peripheral from the same table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lpc_host_bridge;

    logic        clk;
    logic        ctrl_nrst_i;
    logic [15:0] ctrl_addr_i;
    logic [7:0]  ctrl_data_i;
    logic        ctrl_lframe_i;
    logic        ctrl_rd_status_i;
    logic        ctrl_wr_status_i;
    logic        ctrl_memory_cycle_i;
    logic [7:0]  ctrl_data_o;
    logic        ctrl_ready_o;
    logic [4:0]  ctrl_host_state_o;
    wire  [3:0]  LPC_LAD;
    logic        LPC_LCLK;
    logic        LPC_LRESET;
    logic        LPC_LFRAME;

    logic        tb_drv;
    logic [3:0]  tb_val;

    assign LPC_LAD = tb_drv ? tb_val : 4'bzzzz;

    lpc_host_bridge #(.SYNC_TIMEOUT(8)) dut (
        .clk_i               (clk),
        .ctrl_nrst_i         (ctrl_nrst_i),
        .ctrl_addr_i         (ctrl_addr_i),
        .ctrl_data_i         (ctrl_data_i),
        .ctrl_lframe_i       (ctrl_lframe_i),
        .ctrl_rd_status_i    (ctrl_rd_status_i),
        .ctrl_wr_status_i    (ctrl_wr_status_i),
        .ctrl_memory_cycle_i (ctrl_memory_cycle_i),
        .ctrl_data_o         (ctrl_data_o),
        .ctrl_ready_o        (ctrl_ready_o),
        .ctrl_host_state_o   (ctrl_host_state_o),
        .LPC_LAD             (LPC_LAD),
        .LPC_LCLK            (LPC_LCLK),
        .LPC_LRESET          (LPC_LRESET),
        .LPC_LFRAME          (LPC_LFRAME)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected clock of bus activity.
    typedef struct packed {
        logic [4:0] st;
        logic       lframe;
        logic       ready;
        logic [3:0] lad;    // value LAD must show this clock
        logic       drv;    // bench (peripheral side) drives LAD this clock
        logic [7:0] data;   // expected ctrl_data_o
        logic       rel;    // drop the controller request during this clock
    } exp_t;

    exp_t       q[$];
    logic [7:0] exp_data;
    int         n_checks;
    int         n_fail;
    int         cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (clock %0d, t=%0t)", name, act, expv, cyc, $time);
        end
    endtask

    // Host-driven clock
    task automatic ph(input logic [4:0] st, input logic [3:0] nib, input logic lf, input logic rel);
        exp_t e;
        e = '{st: st, lframe: lf, ready: 1'b0, lad: nib, drv: 1'b0, data: exp_data, rel: rel};
        q.push_back(e);
    endtask

    // Clock where the host must be off the bus; bench drives v
    task automatic pp(input logic [4:0] st, input logic [3:0] v, input logic rdy);
        exp_t e;
        e = '{st: st, lframe: 1'b1, ready: rdy, lad: v, drv: 1'b1, data: exp_data, rel: 1'b0};
        q.push_back(e);
    endtask

    // Expand one LPC cycle into per-clock expectations.
    task automatic txn(input bit mem, input bit wr, input logic [15:0] addr, input logic [7:0] data,
                       input int nwait, input logic [3:0] wcode, input logic [3:0] sync_term,
                       input bit abort, input logic [7:0] rdata, input bit rel);
        logic [31:0] a32;
        logic [3:0]  cyct;
        int          n;
        if (!mem && !wr)     cyct = 4'b0000;
        else if (!mem && wr) cyct = 4'b0010;
        else if (mem && !wr) cyct = 4'b0100;
        else                 cyct = 4'b0110;
        a32 = {16'h0000, addr};
        n   = mem ? 8 : 4;
        ph(5'd1, 4'h0, 1'b0, rel);
        ph(5'd2, cyct, 1'b1, 1'b0);
        for (int i = n - 1; i >= 0; i--) ph(5'd3, a32[i*4 +: 4], 1'b1, 1'b0);
        if (wr) begin
            ph(5'd4, data[3:0], 1'b1, 1'b0);
            ph(5'd5, data[7:4], 1'b1, 1'b0);
        end
        ph(5'd6, 4'hF, 1'b1, 1'b0);
        pp(5'd7, 4'h0, 1'b0);
        if (abort) begin
            for (int i = 0; i < 8; i++) pp(5'd8, 4'hF, 1'b0);
            if (!wr) exp_data = 8'hFF;
        end else begin
            for (int i = 0; i < nwait; i++) pp(5'd8, wcode, 1'b0);
            pp(5'd8, sync_term, 1'b0);
            if (!wr) begin
                pp(5'd9,  rdata[3:0], 1'b0);
                pp(5'd10, rdata[7:4], 1'b0);
                exp_data = rdata;
            end
            pp(5'd11, 4'h0, 1'b0);
            pp(5'd12, 4'h0, 1'b0);
        end
        pp(5'd0, 4'h0, 1'b1);
    endtask

    // Play the queue: drive after the edge, compare on the falling edge.
    task automatic run_queue();
        exp_t e;
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e      = q.pop_front();
            tb_drv = e.drv;
            tb_val = e.lad;
            if (e.rel) begin
                ctrl_lframe_i    = 1'b1;
                ctrl_rd_status_i = 1'b0;
                ctrl_wr_status_i = 1'b0;
            end
            @(negedge clk);
            chk("state",  {27'd0, ctrl_host_state_o}, {27'd0, e.st});
            chk("lframe", {31'd0, LPC_LFRAME},        {31'd0, e.lframe});
            chk("ready",  {31'd0, ctrl_ready_o},      {31'd0, e.ready});
            chk("lad",    {28'd0, LPC_LAD},           {28'd0, e.lad});
            chk("data",   {24'd0, ctrl_data_o},       {24'd0, e.data});
            chk("lreset", {31'd0, LPC_LRESET},        32'd1);
        end
    endtask

    task automatic request(input bit mem, input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
        ctrl_memory_cycle_i = mem;
        ctrl_rd_status_i    = rd;
        ctrl_wr_status_i    = wr;
        ctrl_addr_i         = a;
        ctrl_data_i         = d;
        ctrl_lframe_i       = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; exp_data = 8'h00;
        ctrl_nrst_i = 1'b0; ctrl_addr_i = '0; ctrl_data_i = '0; ctrl_lframe_i = 1'b1;
        ctrl_rd_status_i = 1'b0; ctrl_wr_status_i = 1'b0; ctrl_memory_cycle_i = 1'b0;
        tb_drv = 1'b1; tb_val = 4'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state",  {27'd0, ctrl_host_state_o}, 32'd0);
        chk("rst_lframe", {31'd0, LPC_LFRAME},        32'd1);
        chk("rst_ready",  {31'd0, ctrl_ready_o},      32'd1);
        chk("rst_data",   {24'd0, ctrl_data_o},       32'h00);
        chk("rst_lreset", {31'd0, LPC_LRESET},        32'd0);
        ctrl_nrst_i = 1'b1;
        @(negedge clk);

        // I/O write 0xF0F0 <- 0x5A
        request(1'b0, 1'b0, 1'b1, 16'hF0F0, 8'h5A);
        txn(1'b0, 1'b1, 16'hF0F0, 8'h5A, 0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1);
        chk("io_wr_len", q.size(), 32'd14);
        run_queue();

        // I/O read both strobes set: write must win -> use read-only here
        request(1'b0, 1'b1, 1'b0, 16'hF0F0, 8'h00);
        txn(1'b0, 1'b0, 16'hF0F0, 8'h00, 0, 4'h0, 4'h0, 1'b0, 8'hA5, 1'b1);
        run_queue();
        chk("io_rd_data", {24'd0, ctrl_data_o}, 32'hA5);

        // Memory write 0x0005 <- 0x05, both strobes set (write wins)
        request(1'b1, 1'b1, 1'b1, 16'h0005, 8'h05);
        txn(1'b1, 1'b1, 16'h0005, 8'h05, 0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1);
        chk("mem_wr_len", q.size(), 32'd18);
        run_queue();

        // Memory read returns 0xC0
        request(1'b1, 1'b1, 1'b0, 16'h1234, 8'h00);
        txn(1'b1, 1'b0, 16'h1234, 8'h00, 0, 4'h0, 4'h0, 1'b0, 8'hC0, 1'b1);
        run_queue();
        chk("mem_rd_data", {24'd0, ctrl_data_o}, 32'hC0);

        // I/O read with 3 long waits then ready, data 0x88
        request(1'b0, 1'b1, 1'b0, 16'h0080, 8'h00);
        txn(1'b0, 1'b0, 16'h0080, 8'h00, 3, 4'b0110, 4'h0, 1'b0, 8'h88, 1'b1);
        run_queue();
        chk("wait_rd_data", {24'd0, ctrl_data_o}, 32'h88);

        // I/O write with 2 short waits and an error SYNC terminator
        request(1'b0, 1'b0, 1'b1, 16'h1A2B, 8'h3C);
        txn(1'b0, 1'b1, 16'h1A2B, 8'h3C, 2, 4'b0101, 4'b1010, 1'b0, 8'h00, 1'b1);
        run_queue();

        // I/O read with floating bus in SYNC -> timeout abort, data 0xFF
        request(1'b0, 1'b1, 1'b0, 16'h0060, 8'h00);
        txn(1'b0, 1'b0, 16'h0060, 8'h00, 0, 4'h0, 4'h0, 1'b1, 8'h00, 1'b1);
        chk("abort_len", q.size(), 32'd17);
        run_queue();
        chk("abort_data", {24'd0, ctrl_data_o}, 32'hFF);

        // Reset during ADDR
        request(1'b0, 1'b0, 1'b1, 16'hFFFF, 8'h00);
        txn(1'b0, 1'b1, 16'hFFFF, 8'h00, 0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1);
        while (q.size() > 4) void'(q.pop_back());
        run_queue();
        #2;
        ctrl_nrst_i = 1'b0;
        #1;
        chk("mrst_state",  {27'd0, ctrl_host_state_o}, 32'd0);
        chk("mrst_lframe", {31'd0, LPC_LFRAME},        32'd1);
        chk("mrst_lreset", {31'd0, LPC_LRESET},        32'd0);
        chk("mrst_ready",  {31'd0, ctrl_ready_o},      32'd1);
        chk("mrst_data",   {24'd0, ctrl_data_o},       32'h00);
        exp_data = 8'h00;
        tb_drv = 1'b1; tb_val = 4'h0;
        #1;
        chk("mrst_lad_z", {28'd0, LPC_LAD}, 32'd0);
        request(1'b0, 1'b0, 1'b1, 16'h0310, 8'h3C);
        repeat (2) begin
            @(negedge clk);
            chk("mrst_hold", {27'd0, ctrl_host_state_o}, 32'd0);
        end

        // Release reset with the request held: two back-to-back writes
        txn(1'b0, 1'b1, 16'h0310, 8'h3C, 0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
        txn(1'b0, 1'b1, 16'h0310, 8'h3C, 0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        ctrl_nrst_i = 1'b1;
        run_queue();
        @(negedge clk);
        chk("final_idle", {27'd0, ctrl_host_state_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lpc_host_bridge.md
Name: lpc_host_bridge

Overview:
- LPC bus host controller: converts a simple parallel control interface (address, data, read/write strobes, memory/I-O select) into LPC START/CYCTYPE/ADDR/DATA/TAR/SYNC nibble sequences on a tri-state LAD bus.
- Returns read data and a ready flag to the controller side.
- Sits between a GPIO/CPU-side controller and any LPC peripheral sharing LAD/LFRAME/LCLK/LRESET.

Parameters:
- SYNC_TIMEOUT, 8, number of consecutive clocks of non-SYNC (not 0000/0101/0110/1010) response tolerated before the cycle is aborted.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- ctrl_nrst_i  input  1  reset, asynchronous, active-low.
- ctrl_addr_i  input  16  target address.
- ctrl_data_i  input  8  write data.
- ctrl_lframe_i  input  1  active-low cycle request (level-sensitive).
- ctrl_rd_status_i  input  1  request is a read.
- ctrl_wr_status_i  input  1  request is a write.
- ctrl_memory_cycle_i  input  1  1 = memory cycle, 0 = I/O cycle.
- ctrl_data_o  output  8  last read data.
- ctrl_ready_o  output  1  high when idle and able to accept a request.
- ctrl_host_state_o  output  5  current state code.
- LPC_LAD  inout  4  LPC multiplexed address/data bus.
- LPC_LCLK  output  1  LPC clock, equal to clk_i (combinational pass-through).
- LPC_LRESET  output  1  LPC reset, equal to ctrl_nrst_i (pass-through).
- LPC_LFRAME  output  1  LPC frame, active low.

Behaviour:
- Reset (ctrl_nrst_i=0, immediate): state IDLE, LAD high-Z, LPC_LFRAME=1, ctrl_ready_o=1, ctrl_data_o=0x00, latched request registers cleared. Reset mid-cycle aborts with no further bus activity.
- States and ctrl_host_state_o codes:
  - 0 IDLE, 1 START, 2 CYCTYPE, 3 ADDR, 4 WDATA_LO, 5 WDATA_HI, 6 HTAR1, 7 HTAR2, 8 SYNC, 9 RDATA_LO, 10 RDATA_HI, 11 PTAR1, 12 PTAR2.
- IDLE: ctrl_ready_o=1, LAD high-Z.
  - If ctrl_lframe_i=0 and (rd or wr) at a rising edge: latch addr, data, direction and memory flag; go to START. Write wins if both rd and wr are set.
  - If neither strobe is set, stay IDLE.
  - Request is level-sensitive: if ctrl_lframe_i is still low on return to IDLE, a new cycle starts with the current inputs.
- START: LAD=0000, LPC_LFRAME=0 for exactly 1 clock; ctrl_ready_o=0 from here until return to IDLE.
- CYCTYPE: LAD = I/O read 0000, I/O write 0010, memory read 0100, memory write 0110.
- ADDR: nibbles driven MSN first, using an internal nibble counter.
  - I/O cycles: 4 nibbles of addr[15:0].
  - Memory cycles: 8 nibbles of {16'h0000, addr}.
- WDATA_LO/HI (writes only): data[3:0] then data[7:4].
- HTAR1: LAD=1111. HTAR2: LAD high-Z. Both states occur for reads (after ADDR) and for writes (after WDATA_HI).
- SYNC: LAD high-Z; sample LAD each clock.
  - 0000 (ready) or 1010 (error): reads go to RDATA_LO; writes go to PTAR1.
  - 0101/0110 (wait): stay; no timeout counting.
  - Any other value: increment timeout counter. At SYNC_TIMEOUT go to IDLE; on a read, ctrl_data_o=0xFF.
- RDATA_LO/HI: sample low nibble then high nibble; ctrl_data_o is updated on the RDATA_HI edge.
- PTAR1, PTAR2: LAD high-Z, 1 clock each; then IDLE.
- Cycle lengths start to IDLE: I/O read or write 13 clocks; memory read or write 17 clocks, plus any SYNC waits.
- Host drives LAD only in START..HTAR1; high-Z everywhere else. Host never drives LAD while the peripheral drives.

Decomposition:
- Package lpc_pkg: state codes, CYCTYPE nibbles, START nibble 0000, SYNC codes (READY 0000, SWAIT 0101, LWAIT 0110, ERR 1010), TAR nibble 1111.
- No sub-module needed; single FSM with nibble counter, timeout counter and LAD output-enable.

Test Plan:
- I/O write addr 0xF0F0 data 0x5A, peripheral SYNC 0000 -> LAD 0000,0010,F,0,F,0,A,5,1111,Z, then SYNC; LFRAME low only in START; ctrl_ready_o returns 1 after 13 clocks.
- I/O read addr 0xF0F0, peripheral returns SYNC 0000 then nibbles 5,A -> ctrl_data_o=0xA5; LAD high-Z from HTAR2 onward.
- Memory write addr 0x0005 data 0x05 -> CYCTYPE 0110, address nibbles 0,0,0,0,0,0,0,5, data 5,0; 17-clock cycle. Memory read returns 0xC0 -> ctrl_data_o=0xC0.
- Read with 3 clocks of SYNC 0110 then 0000, data 0x88 -> state held at 8 for 3 extra clocks; ctrl_data_o=0x88.
- Read with LAD floating (1111) in SYNC -> abort after 8 clocks to IDLE, ctrl_data_o=0xFF.
- Assert ctrl_nrst_i=0 during ADDR -> immediate IDLE, LAD high-Z, LPC_LFRAME=1, LPC_LRESET=0; ctrl_lframe_i held low with wr=1 after reset -> back-to-back write cycles.
